// File: rtl/rv_shifter_seq.sv
// rv_shifter_seq -- multi-cycle barrel-free shifter for the execute stage.
//
// Accepts a shift from decode, iterates it one bit per cycle (or four bits per
// cycle while at least four remain when RV_SHIFTER_SEQ_STEP4_EN is defined),
// holds the pipeline via x_stall_req_o while busy, and presents the result for
// as long as the execute stage is stalled.
//
// Build option:
//   RV_SHIFTER_SEQ_STEP4_EN  -- shift by 4 per cycle while count >= 4.
//
// Ports:
//   clk_i            clock, rising edge
//   rst_n_i          asynchronous active-low reset
//   x_stall_i        execute stage stalled (holds DONE)
//   w_stall_req_i    writeback stall request, blocks acceptance
//   d_valid_i        decode instruction valid
//   d_is_shift_i     decode instruction is a shift
//   d_rs1_i          operand
//   d_shamt_i        shift amount
//   d_fun_i          function code (FUNC_SL shifts left, anything else right)
//   d_shifter_sign_i arithmetic right shift when set
//   x_stall_req_o    stall request while the shift is in progress
//   x_rd_o           shift result (held outside DONE)
//   x_rd_valid_o     x_rd_o holds a completed result
module rv_shifter_seq (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        x_stall_i,
  input  logic        w_stall_req_i,
  input  logic        d_valid_i,
  input  logic        d_is_shift_i,
  input  logic [31:0] d_rs1_i,
  input  logic [4:0]  d_shamt_i,
  input  logic [2:0]  d_fun_i,
  input  logic        d_shifter_sign_i,
  output logic        x_stall_req_o,
  output logic [31:0] x_rd_o,
  output logic        x_rd_valid_o
);

  // Function codes, same values as rv_defs.v (RISC-V funct3 for SLL / SRL-SRA).
  localparam logic [2:0] FUNC_SL = 3'b001;
  localparam logic [2:0] FUNC_SR = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] work_q;
  logic [4:0]  cnt_q;
  logic        left_q;
  logic        fill_q;
  logic [31:0] rd_q;

  logic        req;
  logic        accept;
  logic        by4;
  logic [31:0] work_nxt;
  logic [4:0]  cnt_nxt;

  // One shift step of the working register; left shifts always fill with 0.
  function automatic logic [31:0] shift_step(input logic [31:0] v,
                                             input logic        left,
                                             input logic        fill,
                                             input logic        four);
    logic [31:0] r;
    if (left)
      r = four ? {v[27:0], 4'b0000} : {v[30:0], 1'b0};
    else
      r = four ? {{4{fill}}, v[31:4]} : {fill, v[31:1]};
    return r;
  endfunction

  assign req    = d_valid_i & d_is_shift_i & ~w_stall_req_i;
  assign accept = (state_q == IDLE) & req;

`ifdef RV_SHIFTER_SEQ_STEP4_EN
  assign by4 = (cnt_q >= 5'd4);
`else
  assign by4 = 1'b0;
`endif

  always_comb begin
    work_nxt = shift_step(work_q, left_q, fill_q, by4);
    cnt_nxt  = cnt_q - (by4 ? 5'd4 : 5'd1);
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic. DONE never re-accepts: decode still holds the
  // instruction that just completed until the stall is released.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = (d_shamt_i != 5'd0) ? SHIFT : DONE;
      SHIFT:   if (cnt_nxt == 5'd0) state_d = DONE;
      DONE:    if (!x_stall_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    x_stall_req_o = 1'b0;
    x_rd_valid_o  = 1'b0;
    case (state_q)
      IDLE:    x_stall_req_o = req;
      SHIFT:   x_stall_req_o = 1'b1;
      DONE:    x_rd_valid_o  = 1'b1;
      default: ;
    endcase
  end

  // Datapath. The result register is written only on entry to DONE so that
  // x_rd_o keeps its previous value while a new operand is being shifted.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      work_q <= '0;
      cnt_q  <= '0;
      left_q <= 1'b0;
      fill_q <= 1'b0;
      rd_q   <= '0;
    end else if (accept) begin
      work_q <= d_rs1_i;
      cnt_q  <= d_shamt_i;
      left_q <= (d_fun_i == FUNC_SL);
      fill_q <= (d_fun_i == FUNC_SR) & d_shifter_sign_i & d_rs1_i[31];
      if (d_shamt_i == 5'd0) rd_q <= d_rs1_i;
    end else if (state_q == SHIFT) begin
      work_q <= work_nxt;
      cnt_q  <= cnt_nxt;
      if (cnt_nxt == 5'd0) rd_q <= work_nxt;
    end
  end

  assign x_rd_o = rd_q;

endmodule

// File: tb/tb_rv_shifter_seq.sv
module tb_rv_shifter_seq;

  localparam logic [2:0] FUNC_SL  = 3'b001;
  localparam logic [2:0] FUNC_SR  = 3'b101;
  localparam logic [2:0] FUNC_ADD = 3'b000;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        x_stall_i;
  logic        w_stall_req_i;
  logic        d_valid_i;
  logic        d_is_shift_i;
  logic [31:0] d_rs1_i;
  logic [4:0]  d_shamt_i;
  logic [2:0]  d_fun_i;
  logic        d_shifter_sign_i;
  logic        x_stall_req_o;
  logic [31:0] x_rd_o;
  logic        x_rd_valid_o;

  rv_shifter_seq dut (
    .clk_i            (clk_i),
    .rst_n_i          (rst_n_i),
    .x_stall_i        (x_stall_i),
    .w_stall_req_i    (w_stall_req_i),
    .d_valid_i        (d_valid_i),
    .d_is_shift_i     (d_is_shift_i),
    .d_rs1_i          (d_rs1_i),
    .d_shamt_i        (d_shamt_i),
    .d_fun_i          (d_fun_i),
    .d_shifter_sign_i (d_shifter_sign_i),
    .x_stall_req_o    (x_stall_req_o),
    .x_rd_o           (x_rd_o),
    .x_rd_valid_o     (x_rd_valid_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] rs1;
    logic [4:0]  shamt;
    logic [2:0]  fun;
    logic        sign;
    logic        xstall;  // hold x_stall_i high from issue through extra DONE cycles
    int          wst;     // cycles w_stall_req_i blocks acceptance first
    logic [31:0] exp_rd;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  int n_vec  = 0;
  int n_miss = 0;
  logic [31:0] exp_q [$];
  int          lat_q [$];
  logic [31:0] prev_rd;

  function automatic int model_lat(input logic [4:0] n);
`ifdef RV_SHIFTER_SEQ_STEP4_EN
    return int'(n) / 4 + int'(n) % 4 + 1;
`else
    return int'(n) + 1;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    d_valid_i        = 1'b0;
    d_is_shift_i     = 1'b0;
    x_stall_i        = 1'b0;
    w_stall_req_i    = 1'b0;
    d_rs1_i          = '0;
    d_shamt_i        = '0;
    d_fun_i          = '0;
    d_shifter_sign_i = 1'b0;
  endtask

  task automatic do_op(input vec_t v);
    int          cyc;
    int          st_cyc;
    bit          got;
    logic [31:0] e_rd;
    int          e_lat;
    @(posedge clk_i); #1;
    d_valid_i        = 1'b1;
    d_is_shift_i     = 1'b1;
    d_rs1_i          = v.rs1;
    d_shamt_i        = v.shamt;
    d_fun_i          = v.fun;
    d_shifter_sign_i = v.sign;
    x_stall_i        = v.xstall;
    w_stall_req_i    = (v.wst != 0);
    exp_q.push_back(v.exp_rd);
    lat_q.push_back(model_lat(v.shamt));
    for (int k = 0; k < v.wst; k++) begin
      @(negedge clk_i);
      check("wstall_blocks_stall_req", {31'b0, x_stall_req_o}, 32'd0);
      check("wstall_no_valid", {31'b0, x_rd_valid_o}, 32'd0);
      @(posedge clk_i); #1;
    end
    w_stall_req_i = 1'b0;
    cyc = 0; st_cyc = 0; got = 1'b0;
    while (cyc < 64 && !got) begin
      @(negedge clk_i);
      if (x_rd_valid_o) got = 1'b1;
      else begin
        if (x_stall_req_o) st_cyc++;
        check("rd_held_while_busy", x_rd_o, prev_rd);
        @(posedge clk_i);
        cyc++;
      end
    end
    e_rd  = exp_q.pop_front();
    e_lat = lat_q.pop_front();
    if (!got) begin
      n_vec++; n_miss++;
      $display("FAIL timeout: no valid after %0d cycles, expected latency %0d", cyc, e_lat);
    end else begin
      check("result", x_rd_o, e_rd);
      check("latency", 32'(cyc), 32'(e_lat));
      check("stall_cycles", 32'(st_cyc), 32'(e_lat));
      check("done_no_stall_req", {31'b0, x_stall_req_o}, 32'd0);
      if (v.xstall) begin
        for (int k = 0; k < 2; k++) begin
          @(posedge clk_i); @(negedge clk_i);
          check("done_hold_valid", {31'b0, x_rd_valid_o}, 32'd1);
          check("done_hold_rd", x_rd_o, e_rd);
          check("done_no_reaccept", {31'b0, x_stall_req_o}, 32'd0);
        end
      end
      x_stall_i = 1'b0;
      d_valid_i = 1'b0;
      @(posedge clk_i); @(negedge clk_i);
      check("idle_valid_low", {31'b0, x_rd_valid_o}, 32'd0);
      check("idle_rd_held", x_rd_o, e_rd);
      check("idle_no_stall_req", {31'b0, x_stall_req_o}, 32'd0);
      prev_rd = e_rd;
    end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   saw_valid;
    vec_t v;

    vecs[0]  = '{32'h0000_0001, 5'd31, FUNC_SL,  1'b0, 1'b0, 0, 32'h8000_0000};
    vecs[1]  = '{32'h8000_0000, 5'd4,  FUNC_SR,  1'b1, 1'b0, 0, 32'hF800_0000};
    vecs[2]  = '{32'h8000_0000, 5'd4,  FUNC_SR,  1'b0, 1'b0, 0, 32'h0800_0000};
    vecs[3]  = '{32'hDEAD_BEEF, 5'd0,  FUNC_SL,  1'b0, 1'b1, 0, 32'hDEAD_BEEF};
    vecs[4]  = '{32'hFFFF_FFFF, 5'd13, FUNC_SR,  1'b0, 1'b0, 3, 32'h0007_FFFF};
    vecs[5]  = '{32'h1234_5678, 5'd8,  FUNC_SR,  1'b1, 1'b1, 0, 32'h0012_3456};
    vecs[6]  = '{32'hF000_0000, 5'd4,  FUNC_ADD, 1'b1, 1'b0, 0, 32'h0F00_0000};
    vecs[7]  = '{32'h8000_0001, 5'd1,  FUNC_SL,  1'b1, 1'b0, 0, 32'h0000_0002};
    vecs[8]  = '{32'h8765_4321, 5'd31, FUNC_SR,  1'b1, 1'b0, 0, 32'hFFFF_FFFF};
    vecs[9]  = '{32'hA5A5_A5A5, 5'd5,  FUNC_SL,  1'b0, 1'b0, 0, 32'hB4B4_B4A0};
    vecs[10] = '{32'h8000_0000, 5'd7,  FUNC_SR,  1'b0, 1'b0, 1, 32'h0100_0000};
    vecs[11] = '{32'hF000_000F, 5'd3,  FUNC_SR,  1'b1, 1'b1, 0, 32'hFE00_0001};

    idle_inputs();
    prev_rd = '0;
    rst_n_i = 1'b0;
    #12;
    check("reset_rd", x_rd_o, 32'd0);
    check("reset_valid", {31'b0, x_rd_valid_o}, 32'd0);
    check("reset_stall_req", {31'b0, x_stall_req_o}, 32'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;

    for (int i = 0; i < NVEC; i++) do_op(vecs[i]);

    // Reset in the middle of a long shift: abort, no result, then recover.
    @(posedge clk_i); #1;
    d_valid_i = 1'b1; d_is_shift_i = 1'b1; d_rs1_i = 32'hFFFF_0000;
    d_shamt_i = 5'd20; d_fun_i = FUNC_SR; d_shifter_sign_i = 1'b0;
    @(negedge clk_i);
    check("abort_accept_stall_req", {31'b0, x_stall_req_o}, 32'd1);
    repeat (5) @(posedge clk_i);
    @(negedge clk_i);
    check("abort_busy_stall_req", {31'b0, x_stall_req_o}, 32'd1);
    d_valid_i = 1'b0;
    rst_n_i = 1'b0;
    #1;
    check("async_reset_rd", x_rd_o, 32'd0);
    check("async_reset_valid", {31'b0, x_rd_valid_o}, 32'd0);
    check("async_reset_stall_req", {31'b0, x_stall_req_o}, 32'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    idle_inputs();
    saw_valid = 1'b0;
    repeat (30) begin
      @(negedge clk_i);
      if (x_rd_valid_o || x_stall_req_o) saw_valid = 1'b1;
    end
    check("abort_no_result", {31'b0, saw_valid}, 32'd0);
    prev_rd = '0;
    v = '{32'h0F0F_0F0F, 5'd20, FUNC_SL, 1'b0, 1'b0, 0, 32'hF0F0_0000};
    do_op(v);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
